// File: rtl/morse_pkg.sv
// Shared types, timing constants and the character-to-Morse lookup for the sequencer.
// Build option MORSE_DIGITS_EN adds digits 0-9 to the lookup.
package morse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MARK,
        ST_SYMGAP,
        ST_LGAP,
        ST_WGAP
    } state_t;

    localparam int         DASH_UNITS = 3;
    localparam int         LGAP_UNITS = 3;
    localparam int         WGAP_UNITS = 4;
    localparam logic [5:0] CODE_SPACE = 6'd36;

    // Returns {len[2:0], pattern[4:0]}; pattern is left-aligned so bit 4 is the first symbol, 1 = dash.
    function automatic logic [7:0] morse_lookup(input logic [5:0] code);
        logic [7:0] r;
        case (code)
            6'd0:  r = {3'd2, 5'b01000};
            6'd1:  r = {3'd4, 5'b10000};
            6'd2:  r = {3'd4, 5'b10100};
            6'd3:  r = {3'd3, 5'b10000};
            6'd4:  r = {3'd1, 5'b00000};
            6'd5:  r = {3'd4, 5'b00100};
            6'd6:  r = {3'd3, 5'b11000};
            6'd7:  r = {3'd4, 5'b00000};
            6'd8:  r = {3'd2, 5'b00000};
            6'd9:  r = {3'd4, 5'b01110};
            6'd10: r = {3'd3, 5'b10100};
            6'd11: r = {3'd4, 5'b01000};
            6'd12: r = {3'd2, 5'b11000};
            6'd13: r = {3'd2, 5'b10000};
            6'd14: r = {3'd3, 5'b11100};
            6'd15: r = {3'd4, 5'b01100};
            6'd16: r = {3'd4, 5'b11010};
            6'd17: r = {3'd3, 5'b01000};
            6'd18: r = {3'd3, 5'b00000};
            6'd19: r = {3'd1, 5'b10000};
            6'd20: r = {3'd3, 5'b00100};
            6'd21: r = {3'd4, 5'b00010};
            6'd22: r = {3'd3, 5'b01100};
            6'd23: r = {3'd4, 5'b10010};
            6'd24: r = {3'd4, 5'b10110};
            6'd25: r = {3'd4, 5'b11000};
`ifdef MORSE_DIGITS_EN
            6'd26: r = {3'd5, 5'b11111};
            6'd27: r = {3'd5, 5'b01111};
            6'd28: r = {3'd5, 5'b00111};
            6'd29: r = {3'd5, 5'b00011};
            6'd30: r = {3'd5, 5'b00001};
            6'd31: r = {3'd5, 5'b00000};
            6'd32: r = {3'd5, 5'b10000};
            6'd33: r = {3'd5, 5'b11000};
            6'd34: r = {3'd5, 5'b11100};
            6'd35: r = {3'd5, 5'b11110};
`endif
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/morse_sequencer_if.sv
// Character offer / key output bundle between a character source and the sequencer.
interface morse_sequencer_if;
    logic       char_valid;
    logic [5:0] char_code;
    logic       char_ready;
    logic       abort;
    logic       key;
    logic       busy;
    logic       done;
    logic       err;

    modport master (output char_valid, char_code, abort,
                    input  char_ready, key, busy, done, err);
    modport slave  (input  char_valid, char_code, abort,
                    output char_ready, key, busy, done, err);
endinterface

// File: rtl/morse_unit_timer.sv
// Purpose: divides clk into Morse time units, one-cycle unit_tick at the end of each unit.
// Latency: first tick UNIT_CYCLES cycles after restart.
// Backpressure: none; free-running, restart reloads the count.
module morse_unit_timer #(
    parameter int UNIT_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic unit_tick
);
    localparam logic [7:0] RELOAD = 8'(UNIT_CYCLES - 1);

    logic [7:0] cnt;

    assign unit_tick = (cnt == 8'd0);

    always_ff @(posedge clk) begin
        if (!reset_n)
            cnt <= 8'd0;
        else if (restart || unit_tick)
            cnt <= RELOAD;
        else
            cnt <= cnt - 8'd1;
    end
endmodule

// File: rtl/morse_sequencer.sv
// Purpose: keys one Morse character (letter, optional digit via MORSE_DIGITS_EN, word space) per offer.
// Latency: key rises the cycle after acceptance; done pulses the cycle after the trailing gap.
// Backpressure: char_ready only in IDLE; abort drops the character in flight.
module morse_sequencer
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    morse_sequencer_if.slave  bus
);
    state_t     state, state_nxt;
    logic [4:0] pat, pat_nxt;
    logic [2:0] sym_left, sym_left_nxt;
    logic [1:0] units, units_nxt, units_load;
    logic       done_q, done_nxt, err_q, err_nxt;
    logic       accept, unit_tick, restart, last_unit;
    logic [7:0] lut;

    morse_unit_timer #(.UNIT_CYCLES(UNIT_CYCLES)) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .restart   (restart),
        .unit_tick (unit_tick)
    );

    always_comb begin
        state_nxt    = state;
        pat_nxt      = pat;
        sym_left_nxt = sym_left;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        units_load   = 2'd0;
        accept       = bus.char_valid && (state == ST_IDLE);
        lut          = morse_lookup(bus.char_code);
        last_unit    = unit_tick && (units == 2'd0);

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.char_code == CODE_SPACE) begin
                        state_nxt = ST_WGAP;
                    end else if (lut[7:5] != 3'd0) begin
                        state_nxt    = ST_MARK;
                        pat_nxt      = lut[4:0];
                        sym_left_nxt = lut[7:5];
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ST_MARK: begin
                if (last_unit) begin
                    pat_nxt      = {pat[3:0], 1'b0};
                    sym_left_nxt = sym_left - 3'd1;
                    state_nxt    = (sym_left > 3'd1) ? ST_SYMGAP : ST_LGAP;
                end
            end
            ST_SYMGAP: if (last_unit) state_nxt = ST_MARK;
            ST_LGAP, ST_WGAP: begin
                if (last_unit) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Abort overrides whatever the character was about to do, including a completion pulse.
        if (bus.abort && state != ST_IDLE) begin
            state_nxt    = ST_IDLE;
            sym_left_nxt = 3'd0;
            done_nxt     = 1'b0;
        end

        restart = accept || (state_nxt != state);

        case (state_nxt)
            ST_MARK: units_load = pat_nxt[4] ? 2'(DASH_UNITS - 1) : 2'd0;
            ST_LGAP: units_load = 2'(LGAP_UNITS - 1);
            ST_WGAP: units_load = 2'(WGAP_UNITS - 1);
            default: units_load = 2'd0;
        endcase

        if (restart)
            units_nxt = units_load;
        else if (unit_tick && units != 2'd0)
            units_nxt = units - 2'd1;
        else
            units_nxt = units;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            pat      <= 5'd0;
            sym_left <= 3'd0;
            units    <= 2'd0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            pat      <= pat_nxt;
            sym_left <= sym_left_nxt;
            units    <= units_nxt;
            done_q   <= done_nxt;
            err_q    <= err_nxt;
        end
    end

    assign bus.key        = (state == ST_MARK);
    assign bus.busy       = (state != ST_IDLE);
    assign bus.char_ready = (state == ST_IDLE);
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_morse_sequencer.sv
// Directed checks of the Morse sequencer at UNIT_CYCLES = 1, 2 and 4; digit case follows MORSE_DIGITS_EN.
module tb_morse_sequencer;
    logic clk = 1'b0;
    logic reset_n;
    int   nchk = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    morse_sequencer_if if1 ();
    morse_sequencer_if if2 ();
    morse_sequencer_if if4 ();

    morse_sequencer #(.UNIT_CYCLES(1)) u1 (.clk(clk), .reset_n(reset_n), .bus(if1));
    morse_sequencer #(.UNIT_CYCLES(2)) u2 (.clk(clk), .reset_n(reset_n), .bus(if2));
    morse_sequencer #(.UNIT_CYCLES(4)) u4 (.clk(clk), .reset_n(reset_n), .bus(if4));

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [0:16] exp_a;
        int          kcount;
        int          dcount;

        if1.char_valid = 1'b0; if1.char_code = 6'd0; if1.abort = 1'b0;
        if2.char_valid = 1'b0; if2.char_code = 6'd0; if2.abort = 1'b0;
        if4.char_valid = 1'b0; if4.char_code = 6'd0; if4.abort = 1'b0;
        reset_n = 1'b0;
        repeat (3) tick();
        chk("rst_key", if1.key, 1'b0);
        chk("rst_busy", if1.busy, 1'b0);
        chk("rst_done", if1.done, 1'b0);
        chk("rst_err", if1.err, 1'b0);
        chk("rst_busy_u2", if2.busy, 1'b0);
        chk("rst_busy_u4", if4.busy, 1'b0);
        reset_n = 1'b1;
        tick();
        chk("rel_ready", if1.char_ready, 1'b1);

        // 'E' at one cycle per unit
        if1.char_valid = 1'b1; if1.char_code = 6'd4;
        tick();
        if1.char_valid = 1'b0;
        chk("e_key_c1", if1.key, 1'b1);
        chk("e_busy_c1", if1.busy, 1'b1);
        chk("e_ready_c1", if1.char_ready, 1'b0);
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk("e_key_gap", if1.key, 1'b0);
            chk("e_done_gap", if1.done, 1'b0);
        end
        tick();
        chk("e_done_c5", if1.done, 1'b1);
        chk("e_ready_c5", if1.char_ready, 1'b1);
        tick();
        chk("e_done_c6", if1.done, 1'b0);

        // 'A' at two cycles per unit: dot, gap, dash, letter gap
        exp_a = 17'b0_11_00_111111_000000;
        if2.char_valid = 1'b1; if2.char_code = 6'd0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if2.char_valid = 1'b0;
            chk("a_key", if2.key, exp_a[c]);
            chk("a_done_early", if2.done, 1'b0);
        end
        tick();
        chk("a_done_c17", if2.done, 1'b1);
        chk("a_ready_c17", if2.char_ready, 1'b1);

        // Word space then 'T' offered back-to-back with char_valid held
        if1.char_valid = 1'b1; if1.char_code = 6'd36;
        tick();
        if1.char_code = 6'd19;
        for (int c = 1; c <= 4; c++) begin
            chk("ws_key", if1.key, 1'b0);
            chk("ws_busy", if1.busy, 1'b1);
            chk("ws_ready", if1.char_ready, 1'b0);
            tick();
        end
        chk("ws_done_c5", if1.done, 1'b1);
        chk("ws_ready_c5", if1.char_ready, 1'b1);
        tick();
        if1.char_valid = 1'b0;
        for (int c = 6; c <= 8; c++) begin
            chk("ws_t_key", if1.key, 1'b1);
            tick();
        end
        chk("ws_t_key_c9", if1.key, 1'b0);
        repeat (4) tick();
        chk("ws_t_idle", if1.char_ready, 1'b1);

        // Invalid code
        if1.char_valid = 1'b1; if1.char_code = 6'd40;
        tick();
        if1.char_valid = 1'b0;
        chk("inv_err_c1", if1.err, 1'b1);
        chk("inv_ready_c1", if1.char_ready, 1'b1);
        chk("inv_key_c1", if1.key, 1'b0);
        chk("inv_done_c1", if1.done, 1'b0);
        tick();
        chk("inv_err_c2", if1.err, 1'b0);

        // Digit '0': five dashes when digits are built in, otherwise rejected
        kcount = 0;
        dcount = 0;
        if1.char_valid = 1'b1; if1.char_code = 6'd26;
`ifdef MORSE_DIGITS_EN
        for (int c = 1; c <= 22; c++) begin
            tick();
            if1.char_valid = 1'b0;
            if (if1.key) kcount++;
            if (if1.done) dcount++;
        end
        tick();
        chk("d0_done_c23", if1.done, 1'b1);
        chk("d0_no_early_done", (dcount == 0), 1'b1);
        nchk++;
        assert (kcount == 15) else begin
            nerr++;
            $error("FAIL d0_key_cycles: observed %0d expected 15", kcount);
        end
`else
        tick();
        if1.char_valid = 1'b0;
        chk("d0_err_c1", if1.err, 1'b1);
        for (int c = 1; c <= 10; c++) begin
            if (if1.key) kcount++;
            tick();
        end
        chk("d0_key_never", (kcount == 0), 1'b1);
`endif
        tick();

        // Abort of 'T' at four cycles per unit
        if4.char_valid = 1'b1; if4.char_code = 6'd19;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if4.char_valid = 1'b0;
            chk("ab_key_mark", if4.key, 1'b1);
        end
        if4.abort = 1'b1;
        tick();
        if4.abort = 1'b0;
        chk("ab_key_c4", if4.key, 1'b0);
        chk("ab_ready_c4", if4.char_ready, 1'b1);
        chk("ab_busy_c4", if4.busy, 1'b0);
        dcount = 0;
        for (int c = 0; c < 20; c++) begin
            if (if4.done || if4.err) dcount++;
            tick();
        end
        chk("ab_no_done", (dcount == 0), 1'b1);

        // Abort and acceptance in the same IDLE cycle: acceptance wins
        if1.char_valid = 1'b1; if1.char_code = 6'd4; if1.abort = 1'b1;
        tick();
        if1.char_valid = 1'b0; if1.abort = 1'b0;
        chk("abidle_key", if1.key, 1'b1);
        chk("abidle_busy", if1.busy, 1'b1);
        repeat (4) tick();
        chk("abidle_done", if1.done, 1'b1);

        // Reset during 'A' at two cycles per unit
        if2.char_valid = 1'b1; if2.char_code = 6'd0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if2.char_valid = 1'b0;
        end
        chk("rs_key_c6", if2.key, 1'b1);
        reset_n = 1'b0;
        tick();
        chk("rs_key_c7", if2.key, 1'b0);
        chk("rs_busy_c7", if2.busy, 1'b0);
        reset_n = 1'b1;
        tick();
        chk("rs_ready_rel", if2.char_ready, 1'b1);
        chk("rs_key_rel", if2.key, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/morse_sequencer.md
MORSE_SEQUENCER -- requirements
Module: morse_sequencer

Interface
REQ-001 Parameter: UNIT_CYCLES, default 4, clock cycles per Morse time unit; legal range 1..255.
REQ-002 clk  input  1  Single clock; all state changes on the rising edge.
REQ-003 reset_n  input  1  Reset, synchronous and active-low.
REQ-004 char_valid  input  1  Character offer, qualified by char_ready.
REQ-005 char_code  input  6  Character code: 0-25 = A-Z, 26-35 = digits 0-9 (REQ-025), 36 = word space, others invalid.
REQ-006 char_ready  output  1  High only in IDLE.
REQ-007 abort  input  1  Synchronous abort of the current character.
REQ-008 key  output  1  Morse key output; high during marks.
REQ-009 busy  output  1  High in any state other than IDLE.
REQ-010 done  output  1  One-cycle pulse on normal completion of a character.
REQ-011 err  output  1  One-cycle pulse after an invalid code is accepted.

Function
REQ-012 States SHALL be IDLE, MARK, SYMGAP, LGAP and WGAP.
REQ-013 A character is accepted in a cycle where char_valid=1 and char_ready=1; char_valid in any other state is ignored.
REQ-014 Timing: dot = 1 unit high; dash = 3 units high; gap between symbols = 1 unit low; gap after a character's last symbol = 3 units low; word space = 4 units low.
REQ-015 Valid letter or digit: the state moves to MARK and key rises in the cycle after acceptance; symbols are sent MSB-first from the lookup; MARK->SYMGAP if symbols remain, else MARK->LGAP; SYMGAP->MARK; LGAP->IDLE.
REQ-016 Code 36: the state moves to WGAP in the cycle after acceptance, key stays 0, and WGAP->IDLE after 4 units.
REQ-017 Invalid code: in the cycle after acceptance the state is IDLE, err=1, key stays 0, and done is not pulsed.
REQ-018 done=1 in the first IDLE cycle after LGAP or WGAP ends; char_ready is also 1 in that cycle, so back-to-back acceptance is allowed.
REQ-019 The unit timer restarts on acceptance and on every state change; each state lasts exactly N*UNIT_CYCLES cycles.
REQ-020 abort=1 in a non-IDLE state: the next cycle is IDLE with key=0; done and err are not pulsed; the character is dropped. abort in IDLE has no effect.
REQ-021 If abort=1 and an acceptance occur in the same IDLE cycle, the acceptance wins.
REQ-022 The timer counter is 8 bits wide; it counts down from UNIT_CYCLES-1 and wraps on the unit tick; no other wrap conditions exist.

Reset
REQ-023 While reset_n=0 at a clock edge: state=IDLE, key=0, done=0, err=0, busy=0, the symbol index is cleared and the timer is cleared.
REQ-024 On the first cycle after release, char_ready=1; reset during a character drops it with key=0 from the next cycle.

Configuration
REQ-025 With MORSE_DIGITS_EN defined, codes 26-35 map to digits 0-9 (5 symbols each); without it, codes 26-35 are invalid per REQ-017, and the symbol store and counter SHALL remain 5 symbols / 3 bits in both builds.

Structure
REQ-026 Package morse_pkg SHALL hold: the state enum; constants DASH_UNITS=3, LGAP_UNITS=3, WGAP_UNITS=4 and CODE_SPACE=36; and the lookup function code -> {len[2:0], pattern[4:0]}, where 1 = dash and invalid returns len=0.
REQ-027 Sub-module morse_unit_timer, parameterised by UNIT_CYCLES, SHALL take a restart input and produce a unit_tick output.

Verification
REQ-028 UNIT_CYCLES=1, 'E' (code 4) accepted at cycle 0 -> key=1 at cycle 1; key=0 at cycles 2-4; done=1 and char_ready=1 at cycle 5.
REQ-029 UNIT_CYCLES=2, 'A' (code 0) accepted at cycle 0 -> key=1 at cycles 1-2, 0 at 3-4, 1 at 5-10, 0 at 11-16; done=1 at cycle 17.
REQ-030 UNIT_CYCLES=1, code 36 accepted at cycle 0, then 'T' offered with char_valid held high -> key=0 at cycles 1-4; done=1 and acceptance at cycle 5; key=1 at cycles 6-8.
REQ-031 Build with MORSE_DIGITS_EN, UNIT_CYCLES=1, code 26 ('0', 5 dashes) -> key high for 15 cycles total within cycles 1-19; done=1 at cycle 23. Build without the macro -> err=1 at cycle 1, key never high.
REQ-032 UNIT_CYCLES=4, 'T' accepted at cycle 0, abort=1 at cycle 3 -> key=0 and char_ready=1 at cycle 4; done never pulses.
REQ-033 reset_n=0 at cycle 6 during 'A' with UNIT_CYCLES=2 -> key=0 and busy=0 at cycle 7; char_ready=1 on the first cycle after release.
